// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit.
//   - RV32 opcode constants decoded by the controller
//   - FSM state encoding (4-bit, S_IDLE = 0)
//   - ALUOp, MemtoReg, ALUSrcA and ALUSrcB select encodings
//   - ctrl_t: bundle of every datapath control output
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // JAL and the JALR writeback drive identical outputs and both return to
    // FETCH, so they share S_JAL. That keeps the full state set within the
    // 4-bit debug encoding.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_LUI      = 4'd5,
        S_AUIPC    = 4'd6,
        S_WB_ALU   = 4'd7,
        S_MEM_ADDR = 4'd8,
        S_MEM_RD   = 4'd9,
        S_WB_MEM   = 4'd10,
        S_MEM_WR   = 4'd11,
        S_BRANCH   = 4'd12,
        S_JAL      = 4'd13,
        S_JALR_EX  = 4'd14,
        S_TRAP     = 4'd15
    } state_e;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_RFUNCT = 2'b10;
    localparam logic [1:0] ALU_IFUNCT = 2'b11;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_ZERO  = 2'b10;
    localparam logic [1:0] SRCA_OLDPC = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_opcode_class.sv
// Opcode classifier used by the DECODE state.
//   opcode     in  7  instruction-register opcode
//   next_state out    state to enter after DECODE
//   is_store   out 1  1 when the memory-class opcode is a store
// With ENABLE_JUMP = 0 the jump/upper-immediate opcodes map to S_TRAP.
module mc_opcode_class
    import rv_ctrl_pkg::*;
#(
    parameter int ENABLE_JUMP = 1
) (
    input  logic [6:0] opcode,
    output state_e     next_state,
    output logic       is_store
);

    localparam logic JUMP_EN = (ENABLE_JUMP != 0);

    always_comb begin
        next_state = S_TRAP;
        is_store   = (opcode == OP_SW);
        case (opcode)
            OP_R:          next_state = S_EXEC_R;
            OP_I:          next_state = S_EXEC_I;
            OP_LW, OP_SW:  next_state = S_MEM_ADDR;
            OP_BEQ:        next_state = S_BRANCH;
            OP_JAL:        next_state = JUMP_EN ? S_JAL     : S_TRAP;
            OP_JALR:       next_state = JUMP_EN ? S_JALR_EX : S_TRAP;
            OP_LUI:        next_state = JUMP_EN ? S_LUI     : S_TRAP;
            OP_AUIPC:      next_state = JUMP_EN ? S_AUIPC   : S_TRAP;
            default:       next_state = S_TRAP;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for a shared-datapath RV32 subset core.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode              IR opcode, sampled only in DECODE
//   zero                ALU zero flag (BRANCH)
//   mem_ready           memory access complete (FETCH, MEM_RD, MEM_WR)
//   PCWrite .. PCSource datapath mux selects and enables
//   instr_done          pulse in the last state of each instruction
//   illegal_instr       trap flag, held until reset
//   state_dbg           current state encoding
//
// state      | meaning
// IDLE       | after reset, all outputs 0, go to FETCH
// FETCH      | read IR at PC, PC <= PC+4 when memory ready
// DECODE     | ALUOut <= OldPC+imm, dispatch on opcode
// EXEC_R     | rs1 op rs2 (R funct)
// EXEC_I     | rs1 op imm (I funct)
// LUI        | 0 + imm
// AUIPC      | OldPC + imm
// WB_ALU     | rd <= ALUOut
// MEM_ADDR   | ALUOut <= rs1 + imm
// MEM_RD     | load read, wait for memory
// WB_MEM     | rd <= MDR
// MEM_WR     | store write, wait for memory
// BRANCH     | compare, PC <= ALUOut if zero
// JAL        | rd <= PC, PC <= ALUOut (also JALR writeback)
// JALR_EX    | ALUOut <= rs1 + imm
// TRAP       | illegal opcode, parked until reset
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int ALUOP_W       = 2,
    parameter int MEM_HANDSHAKE = 1,
    parameter int ENABLE_JUMP   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [1:0]         MemtoReg,
    output logic               RegWrite,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               PCSource,
    output logic               instr_done,
    output logic               illegal_instr,
    output logic [3:0]         state_dbg
);

    state_e state_q, state_d;
    logic   is_store_q, is_store_d;
    state_e dec_next;
    logic   dec_is_store;
    logic   ready;
    ctrl_t  c;

    assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    mc_opcode_class #(
        .ENABLE_JUMP (ENABLE_JUMP)
    ) u_class (
        .opcode     (opcode),
        .next_state (dec_next),
        .is_store   (dec_is_store)
    );

    // The load/store choice is latched in DECODE so MEM_ADDR does not
    // depend on opcode after decode.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (ready) state_d = S_DECODE;
            S_DECODE: begin
                state_d    = dec_next;
                is_store_d = dec_is_store;
            end
            S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC:
                        state_d = S_WB_ALU;
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL:
                        state_d = S_FETCH;
            S_MEM_ADDR: state_d = is_store_q ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (ready) state_d = S_WB_MEM;
            S_MEM_WR:   if (ready) state_d = S_FETCH;
            S_JALR_EX:  state_d = S_JAL;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
        end
    end

    always_comb begin
        c = '0;
        case (state_q)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.ir_write  = ready;
                c.pc_write  = ready;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALU_RFUNCT;
            end
            S_EXEC_I: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_IFUNCT;
            end
            S_LUI: begin
                c.alu_src_a = SRCA_ZERO;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_AUIPC: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_WB_ALU: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_ALUOUT;
                c.instr_done = 1'b1;
            end
            S_MEM_ADDR, S_JALR_EX: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_MDR;
                c.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write  = 1'b1;
                c.iord       = 1'b1;
                c.instr_done = ready;
            end
            S_BRANCH: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.alu_op     = ALU_SUB;
                c.pc_source  = 1'b1;
                c.pc_write   = zero;
                c.instr_done = 1'b1;
            end
            S_JAL: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_PC;
                c.pc_write   = 1'b1;
                c.pc_source  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_TRAP:  c.illegal = 1'b1;
            default: c = '0;
        endcase
    end

    assign PCWrite       = c.pc_write;
    assign IRWrite       = c.ir_write;
    assign IorD          = c.iord;
    assign MemRead       = c.mem_read;
    assign MemWrite      = c.mem_write;
    assign MemtoReg      = c.mem_to_reg;
    assign RegWrite      = c.reg_write;
    assign ALUSrcA       = c.alu_src_a;
    assign ALUSrcB       = c.alu_src_b;
    assign PCSource      = c.pc_source;
    assign instr_done    = c.instr_done;
    assign illegal_instr = c.illegal;
    assign state_dbg     = state_q;

    always_comb begin
        ALUOp      = '0;
        ALUOp[1:0] = c.alu_op;
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
    import rv_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_cnt, done_at, done_cnt;

    // main DUT: default parameters (handshake on, jumps on)
    logic       rst, zero, mem_ready;
    logic [6:0] opcode;
    logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, PCSource;
    logic       instr_done, illegal_instr;
    logic [1:0] MemtoReg, ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0] state_dbg;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .instr_done(instr_done), .illegal_instr(illegal_instr), .state_dbg(state_dbg)
    );

    // second DUT: no handshake, jumps disabled, wide ALUOp
    logic       rst2, zero2, mem_ready2;
    logic [6:0] opcode2;
    logic       pcw2, irw2, iord2, mr2, mw2, rw2, pcs2, done2, ill2;
    logic [1:0] m2r2, sa2, sb2;
    logic [3:0] aop2, st2;

    multicycle_control #(.ALUOP_W(4), .MEM_HANDSHAKE(0), .ENABLE_JUMP(0)) dut2 (
        .clk(clk), .rst(rst2), .opcode(opcode2), .zero(zero2), .mem_ready(mem_ready2),
        .PCWrite(pcw2), .IRWrite(irw2), .IorD(iord2), .MemRead(mr2),
        .MemWrite(mw2), .MemtoReg(m2r2), .RegWrite(rw2),
        .ALUSrcA(sa2), .ALUSrcB(sb2), .ALUOp(aop2), .PCSource(pcs2),
        .instr_done(done2), .illegal_instr(ill2), .state_dbg(st2)
    );

    logic [20:0] obs;
    assign obs = {state_dbg, PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg,
                  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_instr};

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic logic [20:0] mk(input logic [3:0] st, input logic pcw, input logic irw,
            input logic iord, input logic mr, input logic mw, input logic [1:0] m2r,
            input logic rw, input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] op,
            input logic pcs, input logic done, input logic ill);
        return {st, pcw, irw, iord, mr, mw, m2r, rw, sa, sb, op, pcs, done, ill};
    endfunction

    // Expected output vectors, one per architectural step
    function automatic logic [20:0] v_idle();     return mk(S_IDLE,    0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,0,0,0); endfunction
    function automatic logic [20:0] v_fetch(input logic r);
                                                   return mk(S_FETCH,   r,r,0,1,0,2'b00,0,2'b00,2'b01,2'b00,0,0,0); endfunction
    function automatic logic [20:0] v_decode();   return mk(S_DECODE,  0,0,0,0,0,2'b00,0,2'b11,2'b10,2'b00,0,0,0); endfunction
    function automatic logic [20:0] v_exec_r();   return mk(S_EXEC_R,  0,0,0,0,0,2'b00,0,2'b01,2'b00,2'b10,0,0,0); endfunction
    function automatic logic [20:0] v_exec_i();   return mk(S_EXEC_I,  0,0,0,0,0,2'b00,0,2'b01,2'b10,2'b11,0,0,0); endfunction
    function automatic logic [20:0] v_lui();      return mk(S_LUI,     0,0,0,0,0,2'b00,0,2'b10,2'b10,2'b00,0,0,0); endfunction
    function automatic logic [20:0] v_auipc();    return mk(S_AUIPC,   0,0,0,0,0,2'b00,0,2'b11,2'b10,2'b00,0,0,0); endfunction
    function automatic logic [20:0] v_wb_alu();   return mk(S_WB_ALU,  0,0,0,0,0,2'b00,1,2'b00,2'b00,2'b00,0,1,0); endfunction
    function automatic logic [20:0] v_mem_addr(); return mk(S_MEM_ADDR,0,0,0,0,0,2'b00,0,2'b01,2'b10,2'b00,0,0,0); endfunction
    function automatic logic [20:0] v_mem_rd();   return mk(S_MEM_RD,  0,0,1,1,0,2'b00,0,2'b00,2'b00,2'b00,0,0,0); endfunction
    function automatic logic [20:0] v_wb_mem();   return mk(S_WB_MEM,  0,0,0,0,0,2'b01,1,2'b00,2'b00,2'b00,0,1,0); endfunction
    function automatic logic [20:0] v_mem_wr(input logic r);
                                                   return mk(S_MEM_WR,  0,0,1,0,1,2'b00,0,2'b00,2'b00,2'b00,0,r,0); endfunction
    function automatic logic [20:0] v_branch(input logic z);
                                                   return mk(S_BRANCH,  z,0,0,0,0,2'b00,0,2'b01,2'b00,2'b01,1,1,0); endfunction
    // JALR writeback is observed in the same state as JAL
    function automatic logic [20:0] v_jal();      return mk(S_JAL,     1,0,0,0,0,2'b10,1,2'b00,2'b00,2'b00,1,1,0); endfunction
    function automatic logic [20:0] v_jalr_ex();  return mk(S_JALR_EX, 0,0,0,0,0,2'b00,0,2'b01,2'b10,2'b00,0,0,0); endfunction
    function automatic logic [20:0] v_trap();     return mk(S_TRAP,    0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,0,0,1); endfunction

    function automatic logic [6:0] junk();
        return 7'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input string tag, input logic [20:0] e, input logic rdy);
        mem_ready = rdy;
        @(negedge clk);
        chk(tag, 32'(obs), 32'(e));
        cyc_cnt++;
        if (instr_done === 1'b1) begin
            done_cnt++;
            done_at = cyc_cnt;
        end
        @(posedge clk);
        #1;
    endtask

    // Walks one instruction through the expected step sequence. fw = fetch
    // wait cycles, mw = memory wait cycles (loads/stores only).
    task automatic run_instr(input logic [6:0] op, input logic z, input int fw, input int mw);
        int base;
        cyc_cnt = 0; done_at = 0; done_cnt = 0; base = 0;
        zero = z;
        for (int i = 0; i < fw; i++) begin
            opcode = junk(); step("fetch_wait", v_fetch(1'b0), 1'b0);
        end
        opcode = junk(); step("fetch", v_fetch(1'b1), 1'b1);
        opcode = op;     step("decode", v_decode(), rb());
        opcode = junk();
        case (op)
            OP_R:     begin step("exec_r", v_exec_r(), rb()); step("wb_alu", v_wb_alu(), rb()); base = 4; end
            OP_I:     begin step("exec_i", v_exec_i(), rb()); step("wb_alu", v_wb_alu(), rb()); base = 4; end
            OP_LUI:   begin step("lui", v_lui(), rb());       step("wb_alu", v_wb_alu(), rb()); base = 4; end
            OP_AUIPC: begin step("auipc", v_auipc(), rb());   step("wb_alu", v_wb_alu(), rb()); base = 4; end
            OP_LW: begin
                step("mem_addr", v_mem_addr(), rb());
                for (int i = 0; i < mw; i++) step("mem_rd_wait", v_mem_rd(), 1'b0);
                step("mem_rd", v_mem_rd(), 1'b1);
                step("wb_mem", v_wb_mem(), rb());
                base = 5;
            end
            OP_SW: begin
                step("mem_addr", v_mem_addr(), rb());
                for (int i = 0; i < mw; i++) step("mem_wr_wait", v_mem_wr(1'b0), 1'b0);
                step("mem_wr", v_mem_wr(1'b1), 1'b1);
                base = 4;
            end
            OP_BEQ:  begin step("branch", v_branch(z), rb()); base = 3; end
            OP_JAL:  begin step("jal", v_jal(), rb()); base = 3; end
            OP_JALR: begin step("jalr_ex", v_jalr_ex(), rb()); step("jalr_wb", v_jal(), rb()); base = 4; end
            default: begin
                for (int i = 0; i < 10; i++) begin
                    opcode = junk(); step("trap", v_trap(), rb());
                end
            end
        endcase
        if (base != 0) begin
            chk("latency", 32'(done_at), 32'(base + fw + ((op == OP_LW || op == OP_SW) ? mw : 0)));
            chk("done_once", 32'(done_cnt), 32'd1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("reset_idle", v_idle(), rb());
    endtask

    task automatic step2(input string tag, input logic [3:0] st, input logic irw,
                         input logic [3:0] aop, input logic ill);
        @(negedge clk);
        chk({tag, "_state"},   32'(st2),  32'(st));
        chk({tag, "_irwrite"}, 32'(irw2), 32'(irw));
        chk({tag, "_aluop"},   32'(aop2), 32'(aop));
        chk({tag, "_illegal"}, 32'(ill2), 32'(ill));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] pool [9];
        logic [6:0] op;
        pool = '{OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

        rst = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
        rst2 = 1'b1; zero2 = 1'b0; mem_ready2 = 1'b0; opcode2 = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step("reset_idle", v_idle(), 1'b0);

        run_instr(OP_R, 1'b0, 0, 0);
        run_instr(OP_LW, 1'b0, 2, 2);
        run_instr(OP_BEQ, 1'b1, 0, 0);
        run_instr(OP_BEQ, 1'b0, 0, 0);
        run_instr(OP_JAL, 1'b0, 0, 0);
        run_instr(OP_JALR, 1'b0, 0, 0);
        run_instr(OP_I, 1'b0, 1, 0);
        run_instr(OP_LUI, 1'b0, 0, 0);
        run_instr(OP_AUIPC, 1'b0, 0, 0);
        run_instr(OP_SW, 1'b0, 0, 3);

        for (int n = 0; n < 40; n++) begin
            op = pool[$urandom_range(0, 8)];
            run_instr(op, rb(), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // reset while a store is waiting on memory
        cyc_cnt = 0;
        zero = 1'b0;
        opcode = junk();  step("sw_fetch", v_fetch(1'b1), 1'b1);
        opcode = OP_SW;   step("sw_decode", v_decode(), 1'b0);
        opcode = junk();  step("sw_addr", v_mem_addr(), 1'b0);
        step("sw_wait", v_mem_wr(1'b0), 1'b0);
        mem_ready = 1'b0;
        do_reset();
        run_instr(OP_SW, 1'b0, 0, 1);

        // illegal opcode traps until reset
        run_instr(7'b1111111, 1'b0, 0, 0);
        do_reset();
        run_instr(OP_R, 1'b0, 0, 0);

        // second instance: handshake ignored, jumps trap, upper ALUOp bits 0
        rst = 1'b1;
        rst2 = 1'b0;
        step2("d2_idle", S_IDLE, 1'b0, 4'b0000, 1'b0);
        step2("d2_fetch", S_FETCH, 1'b1, 4'b0000, 1'b0);
        opcode2 = OP_I;
        step2("d2_decode", S_DECODE, 1'b0, 4'b0000, 1'b0);
        opcode2 = junk();
        step2("d2_exec_i", S_EXEC_I, 1'b0, 4'b0011, 1'b0);
        step2("d2_wb_alu", S_WB_ALU, 1'b0, 4'b0000, 1'b0);
        step2("d2_fetch", S_FETCH, 1'b1, 4'b0000, 1'b0);
        opcode2 = OP_R;
        step2("d2_decode", S_DECODE, 1'b0, 4'b0000, 1'b0);
        step2("d2_exec_r", S_EXEC_R, 1'b0, 4'b0010, 1'b0);
        step2("d2_wb_alu", S_WB_ALU, 1'b0, 4'b0000, 1'b0);
        step2("d2_fetch", S_FETCH, 1'b1, 4'b0000, 1'b0);
        opcode2 = OP_LW;
        step2("d2_decode", S_DECODE, 1'b0, 4'b0000, 1'b0);
        step2("d2_mem_addr", S_MEM_ADDR, 1'b0, 4'b0000, 1'b0);
        step2("d2_mem_rd", S_MEM_RD, 1'b0, 4'b0000, 1'b0);
        step2("d2_wb_mem", S_WB_MEM, 1'b0, 4'b0000, 1'b0);
        step2("d2_fetch", S_FETCH, 1'b1, 4'b0000, 1'b0);
        opcode2 = OP_JAL;
        step2("d2_decode", S_DECODE, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            opcode2 = junk();
            step2("d2_trap", S_TRAP, 1'b0, 4'b0000, 1'b1);
        end
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        step2("d2_reset_idle", S_IDLE, 1'b0, 4'b0000, 1'b0);
        step2("d2_fetch_after_reset", S_FETCH, 1'b1, 4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
